// File: rtl/psram_pkg.sv
// Shared definitions for the QSPI/QPI PSRAM link, used by both the responder
// and the initiator-side driver.
//   ADDR_BUS_W    : width of the address carried on the link
//   CMD_*         : command opcodes understood by the responder
//   psram_state_e : responder transaction states
package psram_pkg;

  localparam int ADDR_BUS_W = 24;

  localparam logic [7:0] CMD_QPI_ENTER = 8'h35;
  localparam logic [7:0] CMD_QPI_EXIT  = 8'hF5;
  localparam logic [7:0] CMD_QREAD     = 8'hEB;
  localparam logic [7:0] CMD_QWRITE    = 8'h38;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RDATA  = 3'd4,
    ST_WDATA  = 3'd5,
    ST_IGNORE = 3'd6
  } psram_state_e;

endpackage

// File: rtl/psram_resp_ram.sv
// Byte-wide simple dual-port RAM backing the PSRAM responder.
// Synchronous write, registered (1 clk) read; written so that it maps onto
// a block RAM. Contents are intentionally not reset.
//   clk   : system clock
//   we    : write enable
//   waddr : write address
//   wdata : write byte
//   raddr : read address
//   rdata : read byte, valid one clk after raddr
module psram_resp_ram #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [7:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/psram_qspi_responder.sv
// Device end of a QSPI/QPI PSRAM link, oversampled on the system clock.
// Decodes SPI-mode QPI-enter, QPI-mode quad read/write/QPI-exit, and serves
// the data from an internal byte RAM (psram_resp_ram).
//   clk, rst    : system clock (>= 4x sclk), async active-high reset
//   mem_sclk    : link clock from the initiator
//   mem_ce_n    : chip enable, active low; its rise ends a transaction
//   mem_sio_in  : data lines from the initiator
//   mem_sio_out : data lines driven back in read data phase
//   mem_sio_oe  : drive enable for mem_sio_out (only during read data)
//   qpi_mode    : quad command mode active
//   busy        : transaction in progress
// ADDR_W must be at least 5 because the address is shifted in a nibble at a
// time straight into the kept low bits.
module psram_qspi_responder
  import psram_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int READ_WAIT = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mem_sclk,
  input  logic       mem_ce_n,
  input  logic [3:0] mem_sio_in,
  output logic [3:0] mem_sio_out,
  output logic       mem_sio_oe,
  output logic       qpi_mode,
  output logic       busy
);

  localparam logic [2:0] S_IDLE   = 3'(ST_IDLE);
  localparam logic [2:0] S_CMD    = 3'(ST_CMD);
  localparam logic [2:0] S_ADDR   = 3'(ST_ADDR);
  localparam logic [2:0] S_WAIT   = 3'(ST_WAIT);
  localparam logic [2:0] S_RDATA  = 3'(ST_RDATA);
  localparam logic [2:0] S_WDATA  = 3'(ST_WDATA);
  localparam logic [2:0] S_IGNORE = 3'(ST_IGNORE);

  localparam int         ADDR_NIBBLES = ADDR_BUS_W / 4;
  localparam logic [2:0] ADDR_LAST    = 3'(ADDR_NIBBLES - 1);
  localparam logic [7:0] WAIT_LAST    = 8'(READ_WAIT - 1);

  logic [1:0] sclk_sync;
  logic [1:0] ce_sync;
  logic [3:0] sio_sync1;
  logic [3:0] sio_sync2;
  logic       sclk_d;
  logic       ce_d;

  logic [2:0]        state;
  logic [2:0]        cnt;
  logic [6:0]        cmd_q;
  logic              is_write;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        wait_cnt;
  logic              wait_done;
  logic              half;
  logic [3:0]        wr_hi;
  logic              enter_pend;
  logic              exit_pend;

  logic              sclk_s;
  logic              ce_s;
  logic [3:0]        sio_s;
  logic              sclk_rise;
  logic              sclk_fall;
  logic              ce_rise;
  logic              ce_fall;
  logic [7:0]        cmd_spi_next;
  logic [7:0]        cmd_qpi_next;
  logic              ram_we;
  logic [7:0]        ram_rdata;

  // Chip enable synchronizer resets to the deasserted (high) level so that
  // reset release does not look like a transaction start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= 2'b00;
      ce_sync   <= 2'b11;
      sio_sync1 <= 4'h0;
      sio_sync2 <= 4'h0;
      sclk_d    <= 1'b0;
      ce_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[0], mem_sclk};
      ce_sync   <= {ce_sync[0], mem_ce_n};
      sio_sync1 <= mem_sio_in;
      sio_sync2 <= sio_sync1;
      sclk_d    <= sclk_sync[1];
      ce_d      <= ce_sync[1];
    end
  end

  assign sclk_s       = sclk_sync[1];
  assign ce_s         = ce_sync[1];
  assign sio_s        = sio_sync2;
  assign sclk_rise    = sclk_s & ~sclk_d;
  assign sclk_fall    = ~sclk_s & sclk_d;
  assign ce_rise      = ce_s & ~ce_d;
  assign ce_fall      = ~ce_s & ce_d;
  assign cmd_spi_next = {cmd_q, sio_s[0]};
  assign cmd_qpi_next = {cmd_q[3:0], sio_s};

  // The low nibble of a write arrives on a rising edge; the byte is written
  // on that same clk. A simultaneous ce_n rise wins and drops the byte.
  assign ram_we = (state == S_WDATA) & sclk_rise & half & ~ce_rise;
  assign busy   = (state != S_IDLE);

  // QPI enter/exit are only recorded during the command and take effect at
  // the closing ce_n rise, so a half-sent command never changes the mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= 3'd0;
      cmd_q       <= 7'd0;
      is_write    <= 1'b0;
      addr        <= '0;
      wait_cnt    <= 8'd0;
      wait_done   <= 1'b0;
      half        <= 1'b0;
      wr_hi       <= 4'h0;
      enter_pend  <= 1'b0;
      exit_pend   <= 1'b0;
      qpi_mode    <= 1'b0;
      mem_sio_out <= 4'h0;
      mem_sio_oe  <= 1'b0;
    end else if (ce_rise) begin
      state       <= S_IDLE;
      mem_sio_oe  <= 1'b0;
      mem_sio_out <= 4'h0;
      enter_pend  <= 1'b0;
      exit_pend   <= 1'b0;
      if (enter_pend) begin
        qpi_mode <= 1'b1;
      end else if (exit_pend) begin
        qpi_mode <= 1'b0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (ce_fall) begin
            state      <= S_CMD;
            cnt        <= 3'd0;
            cmd_q      <= 7'd0;
            enter_pend <= 1'b0;
            exit_pend  <= 1'b0;
          end
        end
        S_CMD: begin
          if (sclk_rise) begin
            cnt <= cnt + 3'd1;
            if (!qpi_mode) begin
              cmd_q <= cmd_spi_next[6:0];
              if (cnt == 3'd7) begin
                enter_pend <= (cmd_spi_next == CMD_QPI_ENTER);
                state      <= S_IGNORE;
              end
            end else begin
              cmd_q <= cmd_qpi_next[6:0];
              if (cnt == 3'd1) begin
                cnt <= 3'd0;
                if (cmd_qpi_next == CMD_QREAD) begin
                  is_write <= 1'b0;
                  state    <= S_ADDR;
                end else if (cmd_qpi_next == CMD_QWRITE) begin
                  is_write <= 1'b1;
                  state    <= S_ADDR;
                end else begin
                  exit_pend <= (cmd_qpi_next == CMD_QPI_EXIT);
                  state     <= S_IGNORE;
                end
              end
            end
          end
        end
        S_ADDR: begin
          if (sclk_rise) begin
            // Upper bus address bits shift out of the top and are dropped.
            addr <= {addr[ADDR_W-5:0], sio_s};
            cnt  <= cnt + 3'd1;
            if (cnt == ADDR_LAST) begin
              cnt       <= 3'd0;
              wait_cnt  <= 8'd0;
              wait_done <= 1'b0;
              half      <= 1'b0;
              state     <= is_write ? S_WDATA : S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // The RAM read of addr runs during the wait; data is ready long
          // before the first drive.
          if (sclk_rise && !wait_done) begin
            wait_cnt <= wait_cnt + 8'd1;
            if (wait_cnt == WAIT_LAST) begin
              wait_done <= 1'b1;
            end
          end else if (sclk_fall && wait_done) begin
            state       <= S_RDATA;
            mem_sio_oe  <= 1'b1;
            mem_sio_out <= ram_rdata[7:4];
            half        <= 1'b0;
          end
        end
        S_RDATA: begin
          if (sclk_fall) begin
            if (!half) begin
              mem_sio_out <= ram_rdata[3:0];
              half        <= 1'b1;
              addr        <= addr + ADDR_W'(1);
            end else begin
              mem_sio_out <= ram_rdata[7:4];
              half        <= 1'b0;
            end
          end
        end
        S_WDATA: begin
          if (sclk_rise) begin
            if (!half) begin
              wr_hi <= sio_s;
              half  <= 1'b1;
            end else begin
              half <= 1'b0;
              addr <= addr + ADDR_W'(1);
            end
          end
        end
        S_IGNORE: begin
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  psram_resp_ram #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (addr),
    .wdata ({wr_hi, sio_s}),
    .raddr (addr),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_psram_qspi_responder.sv
// Self-checking bench for psram_qspi_responder. Acts as the link initiator
// and keeps a byte-array model of the responder RAM and QPI mode.
module tb_psram_qspi_responder;

  localparam int ADDR_W    = 12;
  localparam int READ_WAIT = 6;
  localparam int DEPTH     = 1 << ADDR_W;
  localparam int HALF      = 60;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mem_sclk = 1'b0;
  logic       mem_ce_n = 1'b1;
  logic [3:0] mem_sio_in = 4'h0;
  logic [3:0] mem_sio_out;
  logic       mem_sio_oe;
  logic       qpi_mode;
  logic       busy;

  psram_qspi_responder #(
    .ADDR_W    (ADDR_W),
    .READ_WAIT (READ_WAIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_sclk    (mem_sclk),
    .mem_ce_n    (mem_ce_n),
    .mem_sio_in  (mem_sio_in),
    .mem_sio_out (mem_sio_out),
    .mem_sio_oe  (mem_sio_oe),
    .qpi_mode    (qpi_mode),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] model_mem [DEPTH];
  bit         model_known [DEPTH];
  logic [7:0] wr_bytes [$];
  logic [3:0] tx_nibs [$];
  logic [3:0] rx_nibs [$];
  logic [7:0] last_read [8];
  int         oe_bad;
  int         oe_high;
  logic       busy_before;
  logic       busy_after;
  logic       qpi_after;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One sclk period: present a nibble during the low phase, sample the
  // responder just before the rising edge, then rise and fall.
  task automatic clockNibble(input logic [3:0] nib, input bit exp_oe, input bit capture);
    mem_sio_in = nib;
    #(HALF - 2);
    if (mem_sio_oe === 1'b1) oe_high++;
    if (mem_sio_oe !== exp_oe) oe_bad++;
    if (capture) rx_nibs.push_back(mem_sio_out);
    #2 mem_sclk = 1'b1;
    #HALF mem_sclk = 1'b0;
  endtask

  // Full transaction: command (SPI bits or QPI nibbles), optional address,
  // wait cycles with junk nibbles, data cycles, then ce_n high.
  task automatic applyStimulus(input bit spi, input logic [7:0] cmd, input bit send_addr,
                               input logic [23:0] addr, input int n_wait, input int n_data,
                               input bit rd_dir, input bit expect_rd_oe);
    oe_bad  = 0;
    oe_high = 0;
    rx_nibs.delete();
    mem_ce_n = 1'b0;
    #HALF;
    if (spi) begin
      for (int i = 7; i >= 0; i--) clockNibble({3'b000, cmd[i]}, 1'b0, 1'b0);
    end else begin
      clockNibble(cmd[7:4], 1'b0, 1'b0);
      clockNibble(cmd[3:0], 1'b0, 1'b0);
    end
    if (send_addr) begin
      for (int i = 5; i >= 0; i--) clockNibble(addr[i*4 +: 4], 1'b0, 1'b0);
    end
    for (int i = 0; i < n_wait; i++) clockNibble(4'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < n_data; i++) begin
      if (rd_dir) clockNibble(4'h0, expect_rd_oe, 1'b1);
      else if (tx_nibs.size() > 0) clockNibble(tx_nibs.pop_front(), 1'b0, 1'b0);
      else clockNibble(4'h0, 1'b0, 1'b0);
    end
    busy_before = busy;
    #HALF;
    mem_ce_n = 1'b1;
    #38;
    qpi_after  = qpi_mode;
    busy_after = busy;
    if (mem_sio_oe !== 1'b0) oe_bad++;
    #HALF;
  endtask

  // Quad write of wr_bytes (plus an optional trailing half byte) at addr;
  // the model only takes whole bytes, wrapping within the RAM depth.
  task automatic doWrite(input logic [23:0] addr, input bit partial, input logic [3:0] extra);
    int n;
    n = wr_bytes.size();
    tx_nibs.delete();
    for (int i = 0; i < n; i++) begin
      tx_nibs.push_back(wr_bytes[i][7:4]);
      tx_nibs.push_back(wr_bytes[i][3:0]);
      model_mem[(int'(addr[ADDR_W-1:0]) + i) % DEPTH]   = wr_bytes[i];
      model_known[(int'(addr[ADDR_W-1:0]) + i) % DEPTH] = 1'b1;
    end
    if (partial) tx_nibs.push_back(extra);
    applyStimulus(1'b0, 8'h38, 1'b1, addr, 0, 2 * n + int'(partial), 1'b0, 1'b0);
    checkOutput("wr_oe_low", oe_high, 0);
    wr_bytes.delete();
  endtask

  // Quad read of n_bytes at addr, compared against the model wherever the
  // model knows the byte; results are also left in last_read.
  task automatic doRead(input logic [23:0] addr, input int n_bytes, input string tag);
    int idx;
    logic [7:0] got;
    applyStimulus(1'b0, 8'hEB, 1'b1, addr, READ_WAIT, 2 * n_bytes, 1'b1, 1'b1);
    checkOutput({tag, "_oe_cycles"}, oe_high, 2 * n_bytes);
    checkOutput({tag, "_oe_window"}, oe_bad, 0);
    for (int i = 0; i < n_bytes; i++) begin
      idx = (int'(addr[ADDR_W-1:0]) + i) % DEPTH;
      got = {rx_nibs[2*i], rx_nibs[2*i+1]};
      if (i < 8) last_read[i] = got;
      if (model_known[idx]) checkOutput({tag, "_data"}, got, model_mem[idx]);
    end
  endtask

  initial begin
    int past [$];
    logic [7:0] prev;
    int a;
    int n;
    logic [11:0] upper;

    #32;
    checkOutput("rst_oe", mem_sio_oe, 0);
    checkOutput("rst_out", mem_sio_out, 0);
    checkOutput("rst_qpi", qpi_mode, 0);
    checkOutput("rst_busy", busy, 0);
    #20 rst = 1'b0;
    #20;

    $display("[TB] SPI QPI-enter");
    applyStimulus(1'b1, 8'h35, 1'b0, 24'h0, 0, 0, 1'b0, 1'b0);
    checkOutput("spi_oe_low", oe_high, 0);
    checkOutput("spi_busy", busy_before, 1);
    checkOutput("qpi_enter", qpi_after, 1);
    checkOutput("busy_drop", busy_after, 0);

    $display("[TB] write/read A5 3C");
    wr_bytes = '{8'hA5, 8'h3C};
    doWrite(24'h000010, 1'b0, 4'h0);
    doRead(24'h000010, 2, "rd_a53c");
    checkOutput("rd_a5", last_read[0], 8'hA5);
    checkOutput("rd_3c", last_read[1], 8'h3C);

    $display("[TB] address wrap");
    wr_bytes = '{8'h11, 8'h22};
    doWrite(24'(DEPTH - 1), 1'b0, 4'h0);
    doRead(24'h000000, 1, "rd_wrap0");
    checkOutput("wrap_lo", last_read[0], 8'h22);
    doRead(24'(DEPTH - 1), 1, "rd_wraptop");
    checkOutput("wrap_hi", last_read[0], 8'h11);
    doRead(24'(DEPTH - 1), 2, "rd_wrapcross");
    checkOutput("wrap_cross", last_read[1], 8'h22);

    $display("[TB] partial byte discard");
    prev = 8'($urandom);
    wr_bytes = '{prev};
    doWrite(24'h000020, 1'b0, 4'h0);
    doWrite(24'h000020, 1'b1, 4'h7);
    doRead(24'h000020, 1, "rd_partial");
    checkOutput("partial_keep", last_read[0], prev);

    $display("[TB] unknown QPI command");
    applyStimulus(1'b0, 8'h9F, 1'b0, 24'h0, 8, 0, 1'b0, 1'b0);
    checkOutput("unk_oe_low", oe_high, 0);
    checkOutput("unk_busy", busy_before, 1);
    checkOutput("unk_busy_drop", busy_after, 0);
    checkOutput("unk_qpi_kept", qpi_after, 1);
    doRead(24'h000010, 2, "rd_after_unk");
    checkOutput("after_unk_a5", last_read[0], 8'hA5);

    $display("[TB] randomized traffic");
    for (int it = 0; it < 12; it++) begin
      n = $urandom_range(1, 4);
      a = (it % 4 == 0) ? DEPTH - 1 - $urandom_range(0, 1) : $urandom_range(0, DEPTH - 1);
      upper = 12'($urandom);
      for (int k = 0; k < n; k++) wr_bytes.push_back(8'($urandom));
      doWrite({upper, a[11:0]}, 1'($urandom_range(0, 1)), 4'($urandom));
      past.push_back(a);
      a = past[$urandom_range(0, past.size() - 1)];
      upper = 12'($urandom);
      doRead({upper, a[11:0]}, $urandom_range(1, 4), "rd_rand");
    end

    $display("[TB] reset during read data");
    mem_ce_n = 1'b0;
    #HALF;
    oe_bad = 0;
    oe_high = 0;
    clockNibble(4'hE, 1'b0, 1'b0);
    clockNibble(4'hB, 1'b0, 1'b0);
    for (int i = 5; i >= 0; i--) clockNibble(4'((24'h000010 >> (i * 4)) & 24'hF), 1'b0, 1'b0);
    for (int i = 0; i < READ_WAIT; i++) clockNibble(4'h0, 1'b0, 1'b0);
    clockNibble(4'h0, 1'b1, 1'b0);
    clockNibble(4'h0, 1'b1, 1'b0);
    #30;
    checkOutput("pre_rst_oe", mem_sio_oe, 1);
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_oe", mem_sio_oe, 0);
    checkOutput("rst_mid_out", mem_sio_out, 0);
    checkOutput("rst_mid_qpi", qpi_mode, 0);
    #29 rst = 1'b0;
    #30 mem_ce_n = 1'b1;
    #(2 * HALF);

    applyStimulus(1'b0, 8'hEB, 1'b1, 24'h000010, READ_WAIT, 4, 1'b1, 1'b0);
    checkOutput("post_rst_eb_oe", oe_high, 0);
    checkOutput("post_rst_eb_window", oe_bad, 0);
    checkOutput("post_rst_qpi", qpi_after, 0);
    applyStimulus(1'b1, 8'h35, 1'b0, 24'h0, 0, 0, 1'b0, 1'b0);
    checkOutput("reenter_qpi", qpi_after, 1);
    doRead(24'h000010, 2, "rd_reenter");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
